// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard controller.
// Pure declarations: no latency, no flow control.
package hazard_pkg;
    typedef enum logic {
        IDLE   = 1'b0,
        LSTALL = 1'b1
    } state_t;

    localparam int REG_ZERO     = 0;
    localparam int LOAD_LAT_MAX = 4;
endpackage

// File: rtl/hazard_load_detect.sv
// Load-use comparator between the load in EX and the instruction in ID.
// Latency: purely combinational. Backpressure: none, result is consumed in-cycle.
module hazard_load_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              hazard_en,
    input  logic              id_ex_memread,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_uses_rt,
    output logic              load_use
);
    logic dst_live;
    logic rs_hit;
    logic rt_hit;

    // Writes to the zero register are discarded, so they can never feed a consumer.
    assign dst_live = (id_ex_rt != REG_AW'(REG_ZERO));
    assign rs_hit   = (id_ex_rt == if_id_rs);
    assign rt_hit   = if_id_uses_rt && (id_ex_rt == if_id_rt);
    assign load_use = hazard_en && id_ex_memread && dst_live && (rs_hit || rt_hit);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, forwarding stalls, memory freeze, branch flush.
// Latency: outputs are combinational from state and inputs (zero-cycle stall response).
// Backpressure: mem_ready low freezes the pipe and holds all state. Optional STALL_STATS_EN adds counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hazard_en,
    input  logic              id_ex_memread,
    input  logic [REG_AW-1:0] id_ex_rt,
    input  logic [REG_AW-1:0] if_id_rs,
    input  logic [REG_AW-1:0] if_id_rt,
    input  logic              if_id_uses_rt,
    input  logic              forward_stall,
    input  logic              mem_ready,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              stall_select,
    output logic              if_id_flush,
    output logic              pipe_freeze
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]       stall_count,
    output logic [31:0]       freeze_count
`endif
);
    localparam int CW = $clog2(LOAD_LAT + 1);

    generate
        if (LOAD_LAT < 1 || LOAD_LAT > LOAD_LAT_MAX) begin : g_bad_lat
            $error("hazard_ctrl_unit: LOAD_LAT must be in 1..4");
        end
    endgenerate

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          load_use;

    hazard_load_detect #(.REG_AW(REG_AW)) u_detect (
        .hazard_en     (hazard_en),
        .id_ex_memread (id_ex_memread),
        .id_ex_rt      (id_ex_rt),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .if_id_uses_rt (if_id_uses_rt),
        .load_use      (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        stall_select = 1'b0;
        if_id_flush  = 1'b0;
        pipe_freeze  = 1'b0;
        if (rst) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (!mem_ready) begin
            // EX is frozen, so a pending branch resolution is not acted on yet.
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            stall_select = 1'b1;
            state_nxt    = IDLE;
            cnt_nxt      = '0;
        end else if (state == LSTALL) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            stall_select = 1'b1;
            cnt_nxt      = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state_nxt = IDLE;
            end
        end else if (load_use) begin
            // The detection cycle is the first bubble; LSTALL covers the rest.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            stall_select = 1'b1;
            if (LOAD_LAT > 1) begin
                state_nxt = LSTALL;
                cnt_nxt   = CW'(LOAD_LAT - 1);
            end
        end else if (forward_stall && hazard_en) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            stall_select = 1'b1;
        end
    end

`ifdef STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count  <= '0;
            freeze_count <= '0;
        end else begin
            if (stall_select && !if_id_flush && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
            if (pipe_freeze && (freeze_count != '1)) begin
                freeze_count <= freeze_count + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus,
// checked every cycle against a bubbles-owed model plus directed literal checks.
module tb_hazard_ctrl_unit;
    localparam int AW = 5;
    localparam logic [4:0] O_IDLE   = 5'b11000;
    localparam logic [4:0] O_STALL  = 5'b00100;
    localparam logic [4:0] O_FREEZE = 5'b00001;
    localparam logic [4:0] O_FLUSH  = 5'b11110;

    logic          clk;
    logic          rst;
    logic          hazard_en;
    logic          id_ex_memread;
    logic [AW-1:0] id_ex_rt;
    logic [AW-1:0] if_id_rs;
    logic [AW-1:0] if_id_rt;
    logic          if_id_uses_rt;
    logic          forward_stall;
    logic          mem_ready;
    logic          branch_taken;

    logic pc_write1, if_id_write1, stall_select1, if_id_flush1, pipe_freeze1;
    logic pc_write3, if_id_write3, stall_select3, if_id_flush3, pipe_freeze3;
    logic [4:0] act [2];

    int n_cmp = 0;
    int n_err = 0;
    int rem [2] = '{0, 0};

`ifdef STALL_STATS_EN
    logic [31:0] sc1, fc1, sc3, fc3;
    logic [31:0] m_sc [2] = '{32'd0, 32'd0};
    logic [31:0] m_fc [2] = '{32'd0, 32'd0};
`endif

    hazard_ctrl_unit #(.REG_AW(AW), .LOAD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .hazard_en(hazard_en), .id_ex_memread(id_ex_memread),
        .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_uses_rt(if_id_uses_rt), .forward_stall(forward_stall),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .pc_write(pc_write1), .if_id_write(if_id_write1), .stall_select(stall_select1),
        .if_id_flush(if_id_flush1), .pipe_freeze(pipe_freeze1)
`ifdef STALL_STATS_EN
        , .stall_count(sc1), .freeze_count(fc1)
`endif
    );

    hazard_ctrl_unit #(.REG_AW(AW), .LOAD_LAT(3)) u3 (
        .clk(clk), .rst(rst), .hazard_en(hazard_en), .id_ex_memread(id_ex_memread),
        .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .if_id_uses_rt(if_id_uses_rt), .forward_stall(forward_stall),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .pc_write(pc_write3), .if_id_write(if_id_write3), .stall_select(stall_select3),
        .if_id_flush(if_id_flush3), .pipe_freeze(pipe_freeze3)
`ifdef STALL_STATS_EN
        , .stall_count(sc3), .freeze_count(fc3)
`endif
    );

    assign act[0] = {pc_write1, if_id_write1, stall_select1, if_id_flush1, pipe_freeze1};
    assign act[1] = {pc_write3, if_id_write3, stall_select3, if_id_flush3, pipe_freeze3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic bit model_load_use();
        return hazard_en && id_ex_memread && (id_ex_rt != 0) &&
               ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    endfunction

    // rem = bubbles still owed to the current load-use after this cycle's.
    function automatic logic [4:0] exp_out(input int r);
        if (rst) return O_IDLE;
        if (!mem_ready) return O_FREEZE;
        if (branch_taken) return O_FLUSH;
        if (r > 0) return O_STALL;
        if (model_load_use()) return O_STALL;
        if (forward_stall && hazard_en) return O_STALL;
        return O_IDLE;
    endfunction

    function automatic int nxt_rem(input int lat, input int r);
        if (rst) return 0;
        if (!mem_ready) return r;
        if (branch_taken) return 0;
        if (r > 0) return r - 1;
        if (model_load_use()) return lat - 1;
        return r;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [4:0] e;
            e = exp_out(rem[i]);
            n_cmp++;
            if (act[i] !== e) begin
                n_err++;
                $display("FAIL model_outputs lat=%0d t=%0t actual=%b required=%b",
                         lat_of(i), $time, act[i], e);
            end
`ifdef STALL_STATS_EN
            n_cmp++;
            if (((i == 0) ? sc1 : sc3) !== m_sc[i] || ((i == 0) ? fc1 : fc3) !== m_fc[i]) begin
                n_err++;
                $display("FAIL stats lat=%0d t=%0t actual=%0d/%0d required=%0d/%0d", lat_of(i),
                         $time, (i == 0) ? sc1 : sc3, (i == 0) ? fc1 : fc3, m_sc[i], m_fc[i]);
            end
            if (rst) begin
                m_sc[i] = 0;
                m_fc[i] = 0;
            end else begin
                if (e[2] && !e[1]) m_sc[i] = m_sc[i] + 1;
                if (e[0]) m_fc[i] = m_fc[i] + 1;
            end
`endif
            rem[i] = nxt_rem(lat_of(i), rem[i]);
        end
    end

    task automatic chk(input string name, input logic [4:0] a, input logic [4:0] e);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%b required=%b", name, $time, a, e);
        end
    endtask

    task automatic quiet();
        hazard_en = 1'b1; id_ex_memread = 1'b0; id_ex_rt = '0; if_id_rs = '0;
        if_id_rt = '0; if_id_uses_rt = 1'b0; forward_stall = 1'b0;
        mem_ready = 1'b1; branch_taken = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hazard3();
        id_ex_memread = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd3;
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        hazard3();
        cyc(); #2;
        chk("reset_u1", act[0], O_IDLE);
        chk("reset_u3", act[1], O_IDLE);
        cyc();
        rst = 1'b0; quiet(); cyc();

        // Basic load-use on rs.
        hazard3(); #2;
        chk("lu_det_u1", act[0], O_STALL);
        chk("lu_det_u3", act[1], O_STALL);
        cyc(); quiet(); #2;
        chk("lu_after_u1", act[0], O_IDLE);
        chk("lu_b2_u3", act[1], O_STALL);
        cyc(); #2; chk("lu_b3_u3", act[1], O_STALL);
        cyc(); #2; chk("lu_done_u3", act[1], O_IDLE);
        cyc();

        // rt match only counts when the ID instruction reads rt.
        id_ex_memread = 1'b1; id_ex_rt = 5'd3; if_id_rs = 5'd5; if_id_rt = 5'd3;
        if_id_uses_rt = 1'b0; #2; chk("rt_unused_u3", act[1], O_IDLE);
        cyc(); if_id_uses_rt = 1'b1; #2; chk("rt_used_u3", act[1], O_STALL);
        cyc(); quiet(); cyc(); cyc();

        id_ex_memread = 1'b1; #2; chk("reg_zero_u3", act[1], O_IDLE);
        cyc(); hazard3(); hazard_en = 1'b0; #2; chk("hz_disabled_u3", act[1], O_IDLE);
        cyc(); quiet(); forward_stall = 1'b1; #2; chk("fwd_stall_u1", act[0], O_STALL);
        cyc(); quiet(); #2; chk("fwd_after_u3", act[1], O_IDLE);
        cyc();

        // Freeze in the middle of LSTALL keeps the bubble count; branch waits.
        hazard3(); cyc(); quiet(); #2; chk("frz_b2", act[1], O_STALL);
        cyc(); mem_ready = 1'b0; branch_taken = 1'b1; #2; chk("frz_1_br", act[1], O_FREEZE);
        cyc(); branch_taken = 1'b0; #2; chk("frz_2", act[1], O_FREEZE);
        cyc(); mem_ready = 1'b1; #2; chk("frz_b3", act[1], O_STALL);
        cyc(); #2; chk("frz_done", act[1], O_IDLE);
        cyc();

        // Taken branch on the second bubble cancels the stall.
        hazard3(); cyc(); quiet(); branch_taken = 1'b1; #2; chk("br_flush", act[1], O_FLUSH);
        cyc(); branch_taken = 1'b0; #2; chk("br_after", act[1], O_IDLE);
        cyc();

        // Reset mid-LSTALL.
        hazard3(); cyc(); quiet(); rst = 1'b1; #2; chk("rst_mid", act[1], O_IDLE);
        cyc(); rst = 1'b0; #2; chk("rst_after", act[1], O_IDLE);
        cyc();

        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 99) < 2);
            hazard_en     = ($urandom_range(0, 9) != 0);
            id_ex_memread = $urandom_range(0, 1);
            id_ex_rt      = AW'($urandom_range(0, 3));
            if_id_rs      = AW'($urandom_range(0, 3));
            if_id_rt      = AW'($urandom_range(0, 3));
            if_id_uses_rt = $urandom_range(0, 1);
            forward_stall = ($urandom_range(0, 9) == 0);
            mem_ready     = ($urandom_range(0, 99) >= 15);
            branch_taken  = ($urandom_range(0, 99) < 8);
            cyc();
        end
        quiet(); rst = 1'b0;
        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised successor to the pipeline hazard unit. Detects load-use hazards between ID/EX and IF/ID and inserts LOAD_LAT bubbles using a stall counter. It also honours single-cycle stall requests from the forwarding unit, freezes the whole front end while data memory is not ready, and flushes IF/ID on a taken branch. It sits beside the forwarding unit and drives the PC, IF/ID and ID/EX-mux enables.

Parameters:
REG_AW, 5, register-address width
LOAD_LAT, 1, bubbles inserted per load-use hazard (legal 1..4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
hazard_en  in  1  enables hazard detection (debug button); 0 = detection off
id_ex_memread  in  1  instruction in EX is a load
id_ex_rt  in  REG_AW  load destination register
if_id_rs  in  REG_AW  source rs of instruction in ID
if_id_rt  in  REG_AW  source rt of instruction in ID
if_id_uses_rt  in  1  ID instruction reads rt (R-type, sw, beq)
forward_stall  in  1  one-cycle stall request from forwarding unit
mem_ready  in  1  data memory ready; 0 = freeze
branch_taken  in  1  branch in EX resolved taken
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
stall_select  out  1  1 = zero ID/EX control (bubble)
if_id_flush  out  1  1 = clear IF/ID to NOP
pipe_freeze  out  1  1 = hold ID/EX, EX/MEM, MEM/WB

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset: state = IDLE, cnt = 0.
- Outputs while rst = 1: pc_write = 1, if_id_write = 1, stall_select = 0, if_id_flush = 0, pipe_freeze = 0.
- load_use (combinational) = hazard_en & id_ex_memread & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | (if_id_uses_rt & id_ex_rt == if_id_rt)).
- Register 0 never causes a hazard.
- States:
  - IDLE: no stall in progress.
  - LSTALL: counting remaining bubbles in cnt (width clog2(LOAD_LAT+1)).
- Outputs are combinational from state plus inputs, so the stall takes effect in the detection cycle with zero latency.
- Priority, highest first:
  1. rst.
  2. mem_ready = 0: pipe_freeze = 1, pc_write = 0, if_id_write = 0, stall_select = 0, if_id_flush = 0. State and cnt hold, and branch_taken is ignored because EX is frozen.
  3. branch_taken = 1: if_id_flush = 1, stall_select = 1, pc_write = 1, if_id_write = 1. Next state is IDLE and cnt = 0, cancelling any LSTALL.
  4. state = LSTALL: pc_write = 0, if_id_write = 0, stall_select = 1. cnt decrements each cycle; at cnt == 1 the next state is IDLE.
  5. IDLE with load_use = 1: stall outputs as in LSTALL. If LOAD_LAT > 1, next state is LSTALL with cnt = LOAD_LAT-1; otherwise stay in IDLE.
  6. IDLE with forward_stall & hazard_en: stall outputs for one cycle; no state change.
  7. Otherwise: pc_write = 1, if_id_write = 1, stall_select = 0, if_id_flush = 0, pipe_freeze = 0.
- Total bubbles per load-use = LOAD_LAT, with mem_ready-low cycles excluded.
- Re-detection during LSTALL is not needed because ID/EX holds a bubble.
- hazard_en falling mid-LSTALL: the current stall completes. hazard_en never masks mem_ready or branch_taken.
- rst during LSTALL or a freeze: IDLE on the next edge.
- LOAD_LAT outside 1..4 is a parameter error (elaboration-time check).

Optional Feature:
STALL_STATS_EN: adds output stall_count [31:0], which increments on every cycle with stall_select = 1 & !if_id_flush, and also output freeze_count [31:0], which increments on every cycle with pipe_freeze = 1. Both clear on rst and saturate at all-ones. Without the macro, neither port nor either counter exists.

Decomposition:
Package hazard_pkg:
- state enum {IDLE, LSTALL}
- REG_ZERO constant
- LOAD_LAT_MAX = 4
Sub-module hazard_load_detect: the combinational load_use comparator, parametrised by REG_AW, so it can be reused for a future second issue slot. The FSM and counter stay in hazard_ctrl_unit.

Test Plan:
- LOAD_LAT = 1; id_ex_memread = 1, id_ex_rt = 3, if_id_rs = 3 for one cycle -> exactly 1 cycle of pc_write = 0, if_id_write = 0, stall_select = 1, then idle values.
- LOAD_LAT = 3; same hazard with if_id_rt = 3 and if_id_uses_rt = 1 -> 3 consecutive stall cycles, state returns to IDLE; with if_id_uses_rt = 0 -> no stall.
- id_ex_rt = 0, if_id_rs = 0, id_ex_memread = 1 -> no stall. hazard_en = 0 with a matching hazard -> no stall. forward_stall = 1 -> single stall cycle.
- LOAD_LAT = 3; mem_ready = 0 for 2 cycles in the middle of LSTALL -> pipe_freeze = 1 and stall_select = 0 for those cycles, total of 3 stall cycles preserved. branch_taken = 1 during a freeze -> no flush until mem_ready = 1.
- LOAD_LAT = 3; branch_taken = 1 on the 2nd stall cycle -> if_id_flush = 1, stall_select = 1, pc_write = 1, LSTALL cancelled, idle values the next cycle.
- rst = 1 during LSTALL -> idle outputs and IDLE state after that edge. With STALL_STATS_EN, 4 stall cycles plus 2 freeze cycles -> stall_count = 4, freeze_count = 2.
